// File: rtl/spoc_bdo_serializer.sv
// spoc_bdo_serializer: captures one SpoC-128 output block or tag from the datapath
// and streams it as PW-bit words, plus the single decrypt status word.
module spoc_bdo_serializer #(
    parameter int PW = 32,
    parameter int BLK_WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] bdo,
    output logic [1:0]    bdo_ctr,
    output logic          sel_tag,
    input  logic          blk_load,
    input  logic [4:0]    blk_bytes,
    input  logic          blk_last,
    input  logic          tag_req,
    input  logic          auth_req,
    input  logic          msg_auth,
    output logic          busy,
    output logic [PW-1:0] do_data,
    output logic          do_valid,
    input  logic          do_ready,
    output logic          do_last
);
    typedef enum logic [2:0] {IDLE, LOAD_D, SEND_D, LOAD_T, SEND_T, STAT} state_t;
    localparam logic [PW-1:0] STAT_OK = {4'hE, {(PW-4){1'b0}}};
    localparam logic [PW-1:0] STAT_FAIL = {4'hF, {(PW-4){1'b0}}};
    state_t state, state_nx;
    logic [1:0] wc, wc_nx, nidx, r;
    logic [PW-1:0] blk_buf [BLK_WORDS];
    logic [PW-1:0] data_nx, word_d;
    logic [2:0] nw, nw_in;
    logic [4:0] bytes_c;
    logic valid_nx, last_nx, last_d, last_f, xfer;
    logic tag_pend, auth_pend, auth_val, tag_go, auth_go, auth_nx;
    assign xfer = do_valid & do_ready;
    assign tag_go = tag_pend | tag_req;
    assign auth_go = auth_pend | auth_req;
    assign auth_nx = auth_req ? msg_auth : auth_val;
    assign bytes_c = (blk_bytes > 5'd16) ? 5'd16 : blk_bytes;
    assign nw_in = 3'((bytes_c + 5'd3) >> 2);
    assign busy = state != IDLE;
    assign sel_tag = state == LOAD_T;
    assign bdo_ctr = (state == LOAD_D || state == LOAD_T) ? wc : 2'd0;
    // Index of the word that goes out next; only the block's final word is byte-masked.
    assign nidx = (state == SEND_D || state == SEND_T) ? wc + 2'd1 : 2'd0;
    assign last_d = last_f && ({1'b0, nidx} == nw - 3'd1);
    assign word_d = blk_buf[nidx] & ((({1'b0, nidx} == nw - 3'd1) && r != 2'd0) ?
                    ~({PW{1'b1}} >> {r, 3'b000}) : {PW{1'b1}});
    always_comb begin
        state_nx = state;
        wc_nx = wc;
        data_nx = do_data;
        valid_nx = do_valid;
        last_nx = do_last;
        case (state)
            IDLE: begin
                wc_nx = 2'd0;
                if (blk_load) state_nx = LOAD_D;
                else if (tag_go) state_nx = LOAD_T;
                else if (auth_go) begin
                    state_nx = STAT;
                    data_nx = auth_nx ? STAT_OK : STAT_FAIL;
                    valid_nx = 1'b1;
                    last_nx = 1'b1;
                end
            end
            LOAD_D, LOAD_T: begin
                wc_nx = wc + 2'd1;
                if (wc == 2'd3) begin
                    if (state == LOAD_T) begin
                        state_nx = SEND_T;
                        data_nx = blk_buf[0];
                        valid_nx = 1'b1;
                        last_nx = 1'b0;
                    end else begin
                        state_nx = (nw == 3'd0) ? IDLE : SEND_D;
                        data_nx = word_d;
                        valid_nx = nw != 3'd0;
                        last_nx = last_d;
                    end
                end
            end
            SEND_D: if (xfer) begin
                if ({1'b0, wc} == nw - 3'd1) begin
                    state_nx = IDLE;
                    wc_nx = 2'd0;
                    data_nx = '0;
                    valid_nx = 1'b0;
                    last_nx = 1'b0;
                end else begin
                    wc_nx = nidx;
                    data_nx = word_d;
                    last_nx = last_d;
                end
            end
            SEND_T: if (xfer) begin
                if (wc == 2'd3) begin
                    state_nx = IDLE;
                    wc_nx = 2'd0;
                    data_nx = '0;
                    valid_nx = 1'b0;
                    last_nx = 1'b0;
                end else begin
                    wc_nx = nidx;
                    data_nx = blk_buf[nidx];
                    last_nx = nidx == 2'd3;
                end
            end
            STAT: if (xfer) begin
                state_nx = IDLE;
                data_nx = '0;
                valid_nx = 1'b0;
                last_nx = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            wc <= 2'd0;
            for (int i = 0; i < BLK_WORDS; i++) blk_buf[i] <= '0;
            tag_pend <= 1'b0;
            auth_pend <= 1'b0;
            auth_val <= 1'b0;
            nw <= 3'd0;
            r <= 2'd0;
            last_f <= 1'b0;
            do_data <= '0;
            do_valid <= 1'b0;
            do_last <= 1'b0;
        end else begin
            state <= state_nx;
            wc <= wc_nx;
            do_data <= data_nx;
            do_valid <= valid_nx;
            do_last <= last_nx;
            if (state == LOAD_D || state == LOAD_T) blk_buf[wc] <= bdo;
            if (state == IDLE && blk_load) begin
                nw <= nw_in;
                r <= bytes_c[1:0];
                last_f <= blk_last;
            end
            // Requests stay pending until their segment actually starts.
            tag_pend <= tag_go & ~(state_nx == LOAD_T && state != LOAD_T);
            auth_pend <= auth_go & ~(state_nx == STAT && state != STAT);
            auth_val <= auth_nx;
        end
    end
endmodule

// File: tb/tb_spoc_bdo_serializer.sv
// tb_spoc_bdo_serializer: randomized self-checking bench; expected word streams come
// from a byte-level model of the block/tag/status output rules.
module tb_spoc_bdo_serializer;
    logic clk = 1'b0, rst = 1'b0;
    logic [31:0] bdo, do_data;
    logic [1:0] bdo_ctr;
    logic sel_tag, busy, do_valid, do_last;
    logic blk_load = 1'b0, blk_last = 1'b0, tag_req = 1'b0, auth_req = 1'b0;
    logic msg_auth = 1'b0, do_ready = 1'b1;
    logic [4:0] blk_bytes = 5'd0;
    int vec = 0, miss = 0;
    logic [31:0] pt_mem [4];
    logic [31:0] tag_mem [4];
    logic [32:0] got_q [$];
    logic [32:0] exp_q [$];

    spoc_bdo_serializer #(.PW(32), .BLK_WORDS(4)) dut (
        .clk(clk), .rst(rst), .bdo(bdo), .bdo_ctr(bdo_ctr), .sel_tag(sel_tag),
        .blk_load(blk_load), .blk_bytes(blk_bytes), .blk_last(blk_last),
        .tag_req(tag_req), .auth_req(auth_req), .msg_auth(msg_auth), .busy(busy),
        .do_data(do_data), .do_valid(do_valid), .do_ready(do_ready), .do_last(do_last)
    );

    always #5 clk = ~clk;
    assign bdo = sel_tag ? tag_mem[bdo_ctr] : pt_mem[bdo_ctr];
    always @(posedge clk) if (rst && do_valid && do_ready) got_q.push_back({do_last, do_data});

    task automatic model_blk(input int nb, input bit lst);
        int nw = (nb + 3) / 4;
        for (int i = 0; i < nw; i++) begin
            logic [31:0] w = pt_mem[i];
            int k = nb % 4;
            if (i == nw - 1 && k != 0) w = (w >> (32 - 8 * k)) << (32 - 8 * k);
            exp_q.push_back({lst && (i == nw - 1), w});
        end
    endtask

    task automatic model_tag();
        for (int i = 0; i < 4; i++) exp_q.push_back({i == 3, tag_mem[i]});
    endtask

    task automatic model_stat(input bit ok);
        exp_q.push_back({1'b1, ok ? 32'hE000_0000 : 32'hF000_0000});
    endtask

    task automatic start_blk(input int nb, input bit lst, input bit tag);
        @(negedge clk);
        for (int i = 0; i < 4; i++) pt_mem[i] = $urandom;
        blk_bytes = 5'(nb);
        blk_last = lst;
        blk_load = 1'b1;
        tag_req = tag;
        @(negedge clk);
        blk_load = 1'b0;
        tag_req = 1'b0;
    endtask

    task automatic run_until_idle(input bit rnd);
        int quiet = 0;
        for (int i = 0; i < 400 && quiet < 3; i++) begin
            @(negedge clk);
            if (rnd) do_ready = 1'($urandom_range(0, 1));
            quiet = busy ? 0 : quiet + 1;
        end
        do_ready = 1'b1;
        @(negedge clk);
        vec++;
        if (quiet < 3) begin
            miss++;
            $display("FAIL idle_timeout: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            pt_mem[i] = 32'h0;
            tag_mem[i] = 32'h0;
        end
        repeat (2) @(negedge clk);
        vec += 6;
        if (busy !== 1'b0) begin miss++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (do_valid !== 1'b0) begin miss++; $display("FAIL rst_valid: got %b, required 0", do_valid); end
        if (do_last !== 1'b0) begin miss++; $display("FAIL rst_last: got %b, required 0", do_last); end
        if (do_data !== 32'h0) begin miss++; $display("FAIL rst_data: got %h, required 0", do_data); end
        if (bdo_ctr !== 2'd0) begin miss++; $display("FAIL rst_ctr: got %0d, required 0", bdo_ctr); end
        if (sel_tag !== 1'b0) begin miss++; $display("FAIL rst_sel: got %b, required 0", sel_tag); end
        rst = 1'b1;
    endtask

    task automatic test_full();
        @(negedge clk);
        for (int i = 0; i < 4; i++) pt_mem[i] = $urandom;
        blk_bytes = 5'd16;
        blk_last = 1'b0;
        blk_load = 1'b1;
        do_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            blk_load = 1'b0;
            vec++;
            if (bdo_ctr !== 2'(k) || sel_tag !== 1'b0 || do_valid !== 1'b0) begin
                miss++;
                $display("FAIL full_ctr%0d: ctr=%0d sel=%b valid=%b, required ctr=%0d sel=0 valid=0",
                         k, bdo_ctr, sel_tag, do_valid, k);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vec++;
            if (do_valid !== 1'b1 || do_data !== pt_mem[k] || do_last !== 1'b0) begin
                miss++;
                $display("FAIL full_word%0d: valid=%b data=%h last=%b, required 1 %h 0",
                         k, do_valid, do_data, do_last, pt_mem[k]);
            end
        end
        @(negedge clk);
        vec++;
        if (busy !== 1'b0 || do_valid !== 1'b0) begin
            miss++;
            $display("FAIL full_idle: busy=%b valid=%b, required 0 0", busy, do_valid);
        end
        got_q.delete();
    endtask

    task automatic test_partial();
        @(negedge clk);
        pt_mem[0] = 32'h1122_3344;
        pt_mem[1] = 32'h5566_7788;
        pt_mem[2] = $urandom;
        pt_mem[3] = $urandom;
        blk_bytes = 5'd6;
        blk_last = 1'b1;
        blk_load = 1'b1;
        @(negedge clk);
        blk_load = 1'b0;
        run_until_idle(1'b0);
        exp_q.push_back({1'b0, 32'h1122_3344});
        exp_q.push_back({1'b1, 32'h5566_0000});
        vec++;
        if (got_q.size() != exp_q.size()) begin
            miss++;
            $display("FAIL partial_count: got %0d words, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vec++;
            if (got_q[i] !== exp_q[i]) begin
                miss++;
                $display("FAIL partial_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        start_blk(16, 0, 1'b0);
        repeat (5) @(negedge clk);
        do_ready = 1'b0;
        held = do_data;
        repeat (3) begin
            @(negedge clk);
            vec++;
            if (do_valid !== 1'b1 || do_data !== held || do_data !== pt_mem[1]) begin
                miss++;
                $display("FAIL bp_hold: valid=%b data=%h, required 1 %h", do_valid, do_data, pt_mem[1]);
            end
        end
        do_ready = 1'b1;
        run_until_idle(1'b0);
        model_blk(16, 1'b0);
        vec++;
        if (got_q.size() != exp_q.size()) begin
            miss++;
            $display("FAIL bp_count: got %0d words, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vec++;
            if (got_q[i] !== exp_q[i]) begin
                miss++;
                $display("FAIL bp_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_tag_status();
        for (int i = 0; i < 4; i++) tag_mem[i] = $urandom;
        @(negedge clk);
        tag_req = 1'b1;
        @(negedge clk);
        tag_req = 1'b0;
        for (int i = 0; i < 4 && !busy; i++) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            vec++;
            if (busy !== 1'b1 || sel_tag !== 1'b1 || bdo_ctr !== 2'(k)) begin
                miss++;
                $display("FAIL tag_load%0d: busy=%b sel=%b ctr=%0d, required 1 1 %0d",
                         k, busy, sel_tag, bdo_ctr, k);
            end
            @(negedge clk);
        end
        run_until_idle(1'b1);
        model_tag();
        for (int s = 0; s < 2; s++) begin
            auth_req = 1'b1;
            msg_auth = 1'(s);
            @(negedge clk);
            auth_req = 1'b0;
            msg_auth = 1'($urandom);
            run_until_idle(1'b1);
            model_stat(1'(s));
        end
        vec++;
        if (got_q.size() != exp_q.size()) begin
            miss++;
            $display("FAIL tagstat_count: got %0d words, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vec++;
            if (got_q[i] !== exp_q[i]) begin
                miss++;
                $display("FAIL tagstat_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_collision();
        int nb = $urandom_range(13, 16);
        bit lst = 1'($urandom);
        bit ok = 1'($urandom);
        for (int i = 0; i < 4; i++) tag_mem[i] = $urandom;
        start_blk(nb, lst, 1'b1);
        @(negedge clk);
        blk_load = 1'b1;
        blk_bytes = 5'd16;
        auth_req = 1'b1;
        msg_auth = ok;
        @(negedge clk);
        blk_load = 1'b0;
        auth_req = 1'b0;
        msg_auth = ~ok;
        run_until_idle(1'b1);
        model_blk(nb, lst);
        model_tag();
        model_stat(ok);
        vec++;
        if (got_q.size() != exp_q.size()) begin
            miss++;
            $display("FAIL coll_count: got %0d words, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            vec++;
            if (got_q[i] !== exp_q[i]) begin
                miss++;
                $display("FAIL coll_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            int nb = $urandom_range(0, 16);
            bit lst = 1'($urandom);
            start_blk(nb, lst, 1'b0);
            model_blk(nb, lst);
            run_until_idle(1'b1);
            vec++;
            if (got_q.size() != exp_q.size()) begin
                miss++;
                $display("FAIL rand%0d_count: bytes=%0d got %0d words, required %0d",
                         n, nb, got_q.size(), exp_q.size());
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                vec++;
                if (got_q[i] !== exp_q[i]) begin
                    miss++;
                    $display("FAIL rand%0d_word%0d: bytes=%0d got %h, required %h",
                             n, i, nb, got_q[i], exp_q[i]);
                end
            end
            got_q.delete();
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        do_ready = 1'b0;
        start_blk(16, 1'b1, 1'b0);
        for (int i = 0; i < 10 && !do_valid; i++) @(negedge clk);
        vec++;
        if (do_valid !== 1'b1) begin
            miss++;
            $display("FAIL rmid_valid: got %b, required 1", do_valid);
        end
        rst = 1'b0;
        #1;
        vec++;
        if (do_valid !== 1'b0 || busy !== 1'b0 || do_last !== 1'b0 || do_data !== 32'h0 || bdo_ctr !== 2'd0) begin
            miss++;
            $display("FAIL rmid_abort: valid=%b busy=%b last=%b data=%h ctr=%0d, required all 0",
                     do_valid, busy, do_last, do_data, bdo_ctr);
        end
        @(negedge clk);
        rst = 1'b1;
        do_ready = 1'b1;
        got_q.delete();
        test_full();
    endtask

    initial begin
        test_reset();
        test_full();
        test_partial();
        test_backpressure();
        test_tag_status();
        test_collision();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
